// File: rtl/a09_fetch_pkg.sv
// Shared types and default sizing for the instruction fetch sequencer.
package a09_fetch_pkg;

    localparam int DATA_WIDTH_DEF     = 16;
    localparam int TIMEOUT_CYCLES_DEF = 15;
    localparam int TIMEOUT_WIDTH_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        INC  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout.sv
// Wait-cycle counter with clear, count enable and terminal-count flag.
module fetch_timeout #(
    parameter int TimeoutWidth  = 4,
    parameter int TimeoutCycles = 15
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clear,
    input  logic Enable,
    output logic Terminal
);

    logic [TimeoutWidth-1:0] count_q;

    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            count_q <= '0;
        end else if (Enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign Terminal = (count_q == TimeoutWidth'(TimeoutCycles - 1));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch sequencer: reads the word at the PC, holds it in IR for decode,
// then strobes the PC increment once decode has taken it.
//
//   state | meaning
//   IDLE  | waiting for Enable (and no Fault) to launch a fetch
//   WAIT  | read outstanding, MemRd held until MemReady or timeout
//   HOLD  | IR valid, waiting for decode to take it
//   INC   | one-cycle PC increment strobe
module instruction_fetch
    import a09_fetch_pkg::*;
#(
    parameter int DataWidth     = DATA_WIDTH_DEF,
    parameter int TimeoutCycles = TIMEOUT_CYCLES_DEF,
    parameter int TimeoutWidth  = TIMEOUT_WIDTH_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 Flush,
    input  logic [DataWidth-1:0] PCAddr,
    output logic                 PCInc_n,
    output logic [DataWidth-1:0] MemAddr,
    output logic                 MemRd,
    input  logic                 MemReady,
    input  logic [DataWidth-1:0] MemData,
    output logic [DataWidth-1:0] IR,
    output logic                 IRValid,
    input  logic                 IRTaken,
    output logic                 Fault
);

    fetch_state_e         state_q, state_d;
    logic [DataWidth-1:0] mem_addr_d, ir_d;
    logic                 mem_rd_d, ir_valid_d, pcinc_n_q, pcinc_n_d, fault_d;
    logic                 cnt_clr, cnt_en, cnt_terminal;

    fetch_timeout #(
        .TimeoutWidth (TimeoutWidth),
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout (
        .Clk     (Clk),
        .Reset   (Reset),
        .Clear   (cnt_clr),
        .Enable  (cnt_en),
        .Terminal(cnt_terminal)
    );

    always_comb begin
        state_d    = state_q;
        mem_addr_d = MemAddr;
        mem_rd_d   = MemRd;
        ir_d       = IR;
        ir_valid_d = IRValid;
        pcinc_n_d  = pcinc_n_q;
        fault_d    = Fault;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        if (Flush) begin
            state_d    = IDLE;
            mem_rd_d   = 1'b0;
            ir_valid_d = 1'b0;
            pcinc_n_d  = 1'b1;
            cnt_clr    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Enable && !Fault) begin
                        mem_addr_d = PCAddr;
                        mem_rd_d   = 1'b1;
                        cnt_clr    = 1'b1;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (MemReady) begin
                        ir_d       = MemData;
                        ir_valid_d = 1'b1;
                        mem_rd_d   = 1'b0;
                        state_d    = HOLD;
                    end else if (cnt_terminal) begin
                        fault_d  = 1'b1;
                        mem_rd_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                HOLD: begin
                    if (IRTaken) begin
                        ir_valid_d = 1'b0;
                        pcinc_n_d  = 1'b0;
                        state_d    = INC;
                    end
                end
                INC: begin
                    pcinc_n_d = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            MemAddr   <= '0;
            MemRd     <= 1'b0;
            IR        <= '0;
            IRValid   <= 1'b0;
            pcinc_n_q <= 1'b1;
            Fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            MemAddr   <= mem_addr_d;
            MemRd     <= mem_rd_d;
            IR        <= ir_d;
            IRValid   <= ir_valid_d;
            pcinc_n_q <= pcinc_n_d;
            Fault     <= fault_d;
        end
    end

    // A flush means the PC is being loaded, so the increment must never land.
    assign PCInc_n = pcinc_n_q | Flush;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small PC model (step 2, loadable).
module tb_instruction_fetch;

    logic        Clk, Reset, Enable, Flush, MemReady, IRTaken;
    logic [15:0] PCAddr, MemData, MemAddr, IR;
    logic        PCInc_n, MemRd, IRValid, Fault;

    logic [15:0] pc, pc_load_val;
    logic        pc_load;
    int          checks, errors;

    instruction_fetch dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Flush(Flush),
        .PCAddr(PCAddr), .PCInc_n(PCInc_n), .MemAddr(MemAddr), .MemRd(MemRd),
        .MemReady(MemReady), .MemData(MemData), .IR(IR), .IRValid(IRValid),
        .IRTaken(IRTaken), .Fault(Fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (Reset)        pc <= 16'h0000;
        else if (pc_load) pc <= pc_load_val;
        else if (!PCInc_n) pc <= pc + 16'd2;
    end
    assign PCAddr = pc;

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Enable = 1'b0;
        step(); step();
        checks++; if (MemAddr !== 16'h0) begin errors++; $display("FAIL reset_memaddr got %h want 0000", MemAddr); end
        checks++; if (MemRd !== 1'b0) begin errors++; $display("FAIL reset_memrd got %b want 0", MemRd); end
        checks++; if (IR !== 16'h0) begin errors++; $display("FAIL reset_ir got %h want 0000", IR); end
        checks++; if (IRValid !== 1'b0) begin errors++; $display("FAIL reset_irvalid got %b want 0", IRValid); end
        checks++; if (PCInc_n !== 1'b1) begin errors++; $display("FAIL reset_pcinc got %b want 1", PCInc_n); end
        checks++; if (Fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", Fault); end
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (MemRd !== 1'b0) begin errors++; $display("FAIL idle_memrd cycle %0d got %b want 0", i, MemRd); end
        end
    endtask

    task automatic test_zero_wait;
        Enable = 1'b1; MemReady = 1'b1; MemData = 16'h1234; IRTaken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (MemAddr !== 16'(2 * k) || MemRd !== 1'b1) begin errors++; $display("FAIL zw_addr got %h/%b want %h/1", MemAddr, MemRd, 16'(2 * k)); end
            step();
            checks++; if (IR !== 16'h1234 || IRValid !== 1'b1) begin errors++; $display("FAIL zw_ir got %h/%b want 1234/1", IR, IRValid); end
            step();
            checks++; if (PCInc_n !== 1'b0 || IRValid !== 1'b0) begin errors++; $display("FAIL zw_inc got pcinc %b irvalid %b want 0/0", PCInc_n, IRValid); end
            if (k == 2) Enable = 1'b0;
            step();
            checks++; if (PCInc_n !== 1'b1 || pc !== 16'(2 * k + 2)) begin errors++; $display("FAIL zw_pc got %b/%h want 1/%h", PCInc_n, pc, 16'(2 * k + 2)); end
        end
        MemReady = 1'b0; IRTaken = 1'b0;
    endtask

    task automatic test_wait_states_and_stall;
        Enable = 1'b1; MemData = 16'hBEEF;
        step();
        Enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (MemRd !== 1'b1 || MemAddr !== 16'h0006) begin errors++; $display("FAIL ws_hold cycle %0d got %b/%h want 1/0006", i, MemRd, MemAddr); end
            if (i == 3) MemReady = 1'b1;
            step();
        end
        MemReady = 1'b0;
        checks++; if (MemRd !== 1'b0 || IR !== 16'hBEEF || IRValid !== 1'b1 || Fault !== 1'b0) begin errors++; $display("FAIL ws_load got rd %b ir %h v %b f %b want 0 beef 1 0", MemRd, IR, IRValid, Fault); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (IR !== 16'hBEEF || IRValid !== 1'b1 || PCInc_n !== 1'b1 || pc !== 16'h0006) begin errors++; $display("FAIL stall cycle %0d got ir %h v %b inc %b pc %h", i, IR, IRValid, PCInc_n, pc); end
        end
        IRTaken = 1'b1;
        step();
        IRTaken = 1'b0;
        checks++; if (PCInc_n !== 1'b0) begin errors++; $display("FAIL stall_inc got %b want 0", PCInc_n); end
        step();
        checks++; if (PCInc_n !== 1'b1 || pc !== 16'h0008) begin errors++; $display("FAIL stall_after got %b/%h want 1/0008", PCInc_n, pc); end
        step();
        checks++; if (PCInc_n !== 1'b1 || pc !== 16'h0008) begin errors++; $display("FAIL stall_once got %b/%h want 1/0008", PCInc_n, pc); end
    endtask

    task automatic test_flush_wait;
        Enable = 1'b1;
        step();
        Enable = 1'b0; Flush = 1'b1;
        step();
        Flush = 1'b0;
        checks++; if (MemRd !== 1'b0 || IR !== 16'hBEEF || IRValid !== 1'b0) begin errors++; $display("FAIL fw_drop got rd %b ir %h v %b want 0 beef 0", MemRd, IR, IRValid); end
        MemReady = 1'b1; MemData = 16'h5555;
        step();
        checks++; if (IR !== 16'hBEEF || IRValid !== 1'b0 || MemRd !== 1'b0) begin errors++; $display("FAIL fw_late_ready got ir %h v %b rd %b", IR, IRValid, MemRd); end
        MemReady = 1'b0; Enable = 1'b1;
        step();
        Enable = 1'b0; Flush = 1'b1; MemReady = 1'b1; MemData = 16'h6666;
        step();
        Flush = 1'b0; MemReady = 1'b0;
        checks++; if (IR !== 16'hBEEF || IRValid !== 1'b0 || MemRd !== 1'b0) begin errors++; $display("FAIL fw_coincide got ir %h v %b rd %b", IR, IRValid, MemRd); end
    endtask

    task automatic test_flush_inc;
        Enable = 1'b1; MemReady = 1'b1; MemData = 16'h7777; IRTaken = 1'b1;
        step();
        Enable = 1'b0;
        step();
        step();
        MemReady = 1'b0; IRTaken = 1'b0;
        Flush = 1'b1; pc_load = 1'b1; pc_load_val = 16'h00A0;
        #1;
        checks++; if (PCInc_n !== 1'b1) begin errors++; $display("FAIL fi_pcinc got %b want 1", PCInc_n); end
        step();
        Flush = 1'b0; pc_load = 1'b0;
        checks++; if (pc !== 16'h00A0 || MemRd !== 1'b0 || IR !== 16'h7777) begin errors++; $display("FAIL fi_pc got pc %h rd %b ir %h want 00a0 0 7777", pc, MemRd, IR); end
        Enable = 1'b1;
        step();
        Enable = 1'b0;
        checks++; if (MemAddr !== 16'h00A0 || MemRd !== 1'b1) begin errors++; $display("FAIL fi_next_addr got %h/%b want 00a0/1", MemAddr, MemRd); end
        Flush = 1'b1;
        step();
        Flush = 1'b0;
    endtask

    task automatic test_timeout;
        Enable = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            checks++; if (MemRd !== 1'b1 || Fault !== 1'b0) begin errors++; $display("FAIL to_wait cycle %0d got rd %b f %b want 1 0", i, MemRd, Fault); end
            step();
        end
        checks++; if (Fault !== 1'b1 || MemRd !== 1'b0 || IR !== 16'h7777) begin errors++; $display("FAIL to_fault got f %b rd %b ir %h want 1 0 7777", Fault, MemRd, IR); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (Fault !== 1'b1 || MemRd !== 1'b0) begin errors++; $display("FAIL to_sticky cycle %0d got f %b rd %b want 1 0", i, Fault, MemRd); end
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++; if (Fault !== 1'b0 || MemRd !== 1'b0) begin errors++; $display("FAIL to_reset got f %b rd %b want 0 0", Fault, MemRd); end
        step();
        checks++; if (MemRd !== 1'b1 || MemAddr !== 16'h0000) begin errors++; $display("FAIL to_refetch got rd %b addr %h want 1 0000", MemRd, MemAddr); end
        Enable = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        Reset = 1'b1; Enable = 1'b0; Flush = 1'b0; MemReady = 1'b0;
        MemData = 16'h0; IRTaken = 1'b0; pc_load = 1'b0; pc_load_val = 16'h0;
        test_reset();
        test_zero_wait();
        test_wait_states_and_stall();
        test_flush_wait();
        test_flush_inc();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
